// File: rtl/flash_cmd_seq_if.sv
// Request/response and flash-controller bus bundle for flash_cmd_seq.
// Handshake: a request transfers on a rising edge where req_valid & req_ready are both 1; the client holds
// req_* stable until then. rsp_valid and fb_action/fb_done are single-cycle pulses with no back-pressure.
interface flash_cmd_seq_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic [7:0] addr;
    logic [7:0] data;
    logic       direction_rw;
    logic       fb_action;
    logic       fb_done;
    logic [7:0] fb_rdata;

    modport master (
        input  req_valid, req_rw, req_addr, req_wdata, fb_done, fb_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data, direction_rw, fb_action
    );

    modport slave (
        output req_valid, req_rw, req_addr, req_wdata, fb_done, fb_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data, direction_rw, fb_action
    );
endinterface

// File: rtl/flash_cmd_seq.sv
// Expands single-byte client read/program requests into StrataFlash command sequences
// (read-array, program, status poll, clear-status) on the byte-level flash controller bus.
module flash_cmd_seq #(
    parameter int unsigned POLL_MAX = 1023,
    parameter logic [7:0]  CMD_READ = 8'hFF,
    parameter logic [7:0]  CMD_PROG = 8'h40,
    parameter logic [7:0]  CMD_STAT = 8'h70,
    parameter logic [7:0]  CMD_CLR  = 8'h50
) (
    input  logic            CLK_50MHZ,
    input  logic            RST,
    flash_cmd_seq_if.master bus,
    output logic [3:0]      state_dbg
);
    localparam int unsigned PW = $clog2(POLL_MAX + 1);

    typedef enum logic [3:0] {
        IDLE, RD_CMD, RD_DATA, PR_SETUP, PR_DATA, ST_CMD, ST_POLL, CLR, RESP
    } state_t;

    state_t        state, state_nxt;
    logic          req_ready_q, req_ready_nxt;
    logic          rsp_valid_q, rsp_valid_nxt;
    logic [7:0]    rsp_rdata_q, rsp_rdata_nxt;
    logic          rsp_err_q, rsp_err_nxt;
    logic [7:0]    addr_q, addr_nxt;
    logic [7:0]    data_q, data_nxt;
    logic          dir_q, dir_nxt;
    logic          fb_action_q, fb_action_nxt;
    logic          array_mode, array_mode_nxt;
    logic [PW-1:0] poll_cnt, poll_cnt_nxt;
    logic [PW-1:0] poll_inc;
    logic [7:0]    wdata_q, wdata_nxt;

    assign poll_inc = poll_cnt + PW'(1);

    // Every bus state issues its transaction on the edge that enters it, then waits for fb_done.
    always_comb begin
        state_nxt      = state;
        req_ready_nxt  = req_ready_q;
        rsp_valid_nxt  = 1'b0;
        rsp_rdata_nxt  = rsp_rdata_q;
        rsp_err_nxt    = rsp_err_q;
        addr_nxt       = addr_q;
        data_nxt       = data_q;
        dir_nxt        = dir_q;
        fb_action_nxt  = 1'b0;
        array_mode_nxt = array_mode;
        poll_cnt_nxt   = poll_cnt;
        wdata_nxt      = wdata_q;
        case (state)
            IDLE: begin
                req_ready_nxt = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    req_ready_nxt = 1'b0;
                    poll_cnt_nxt  = '0;
                    wdata_nxt     = bus.req_wdata;
                    addr_nxt      = bus.req_addr;
                    fb_action_nxt = 1'b1;
                    if (bus.req_rw) begin
                        state_nxt      = PR_SETUP;
                        array_mode_nxt = 1'b0;
                        dir_nxt        = 1'b1;
                        data_nxt       = CMD_PROG;
                    end else if (array_mode) begin
                        state_nxt = RD_DATA;
                        dir_nxt   = 1'b0;
                    end else begin
                        state_nxt = RD_CMD;
                        dir_nxt   = 1'b1;
                        data_nxt  = CMD_READ;
                    end
                end
            end
            RD_CMD: if (bus.fb_done) begin
                array_mode_nxt = 1'b1;
                state_nxt      = RD_DATA;
                dir_nxt        = 1'b0;
                fb_action_nxt  = 1'b1;
            end
            RD_DATA: if (bus.fb_done) begin
                rsp_rdata_nxt = bus.fb_rdata;
                rsp_err_nxt   = 1'b0;
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            PR_SETUP: if (bus.fb_done) begin
                state_nxt     = PR_DATA;
                data_nxt      = wdata_q;
                fb_action_nxt = 1'b1;
            end
            PR_DATA: if (bus.fb_done) begin
                state_nxt     = ST_CMD;
                data_nxt      = CMD_STAT;
                fb_action_nxt = 1'b1;
            end
            ST_CMD: if (bus.fb_done) begin
                state_nxt     = ST_POLL;
                dir_nxt       = 1'b0;
                fb_action_nxt = 1'b1;
            end
            ST_POLL: if (bus.fb_done) begin
                // SR[7] = ready; SR[4]/SR[3]/SR[1] = program, VPP and block-lock errors.
                rsp_rdata_nxt = bus.fb_rdata;
                poll_cnt_nxt  = poll_inc;
                if (bus.fb_rdata[7] && !(bus.fb_rdata[4] || bus.fb_rdata[3] || bus.fb_rdata[1])) begin
                    rsp_err_nxt   = 1'b0;
                    rsp_valid_nxt = 1'b1;
                    state_nxt     = RESP;
                end else if (bus.fb_rdata[7] || poll_inc >= PW'(POLL_MAX)) begin
                    rsp_err_nxt   = 1'b1;
                    state_nxt     = CLR;
                    dir_nxt       = 1'b1;
                    data_nxt      = CMD_CLR;
                    fb_action_nxt = 1'b1;
                end else begin
                    fb_action_nxt = 1'b1;
                end
            end
            CLR: if (bus.fb_done) begin
                rsp_valid_nxt = 1'b1;
                state_nxt     = RESP;
            end
            RESP: begin
                req_ready_nxt = 1'b1;
                state_nxt     = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHZ) begin
        if (!RST) begin
            state       <= IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            rsp_err_q   <= 1'b0;
            addr_q      <= 8'h00;
            data_q      <= 8'h00;
            dir_q       <= 1'b0;
            fb_action_q <= 1'b0;
            array_mode  <= 1'b0;
            poll_cnt    <= '0;
            wdata_q     <= 8'h00;
        end else begin
            state       <= state_nxt;
            req_ready_q <= req_ready_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_rdata_q <= rsp_rdata_nxt;
            rsp_err_q   <= rsp_err_nxt;
            addr_q      <= addr_nxt;
            data_q      <= data_nxt;
            dir_q       <= dir_nxt;
            fb_action_q <= fb_action_nxt;
            array_mode  <= array_mode_nxt;
            poll_cnt    <= poll_cnt_nxt;
            wdata_q     <= wdata_nxt;
        end
    end

    assign bus.req_ready    = req_ready_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_err      = rsp_err_q;
    assign bus.addr         = addr_q;
    assign bus.data         = data_q;
    assign bus.direction_rw = dir_q;
    assign bus.fb_action    = fb_action_q;
    assign state_dbg        = state;
endmodule

// File: tb/tb_flash_cmd_seq.sv
// Bench for flash_cmd_seq: responder model of the flash controller plus a command-sequence reference model.
module tb_flash_cmd_seq;
    localparam int POLL_MAX = 4;

    logic CLK_50MHZ = 1'b0;
    logic RST;
    logic [3:0] state_dbg;
    flash_cmd_seq_if bus();

    flash_cmd_seq #(.POLL_MAX(POLL_MAX)) dut (
        .CLK_50MHZ(CLK_50MHZ),
        .RST(RST),
        .bus(bus),
        .state_dbg(state_dbg)
    );

    always #5 CLK_50MHZ = ~CLK_50MHZ;

    int total = 0;
    int bad = 0;
    logic [16:0] obs_q[$];
    logic [16:0] exp_q[$];
    bit          exp_acare[$];
    logic [7:0]  rd_q[$];
    logic [7:0]  sr_script[$];
    bit          busy = 0;
    int          delay = 0;
    logic [7:0]  rd_next = 8'h00;
    logic [16:0] cur_txn = '0;
    time         done_time = 0;
    bit          chk_stable = 1;
    bit          slow_en = 0;
    logic [7:0]  slow_data = 8'h00;
    bit          model_am = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Flash controller responder: records each transaction, answers after a random delay.
    always @(negedge CLK_50MHZ) begin
        bus.fb_done = 1'b0;
        if (bus.fb_action === 1'b1) begin
            chk("txn_overlap", 32'(busy), 32'd0);
            cur_txn = {bus.direction_rw, bus.addr, bus.data};
            obs_q.push_back(cur_txn);
            busy = 1;
            delay = (slow_en && bus.direction_rw && bus.data == slow_data) ? 12 : int'($urandom_range(1, 4));
            if (!bus.direction_rw && rd_q.size() > 0) rd_next = rd_q.pop_front();
            else if (!bus.direction_rw) rd_next = 8'hEE;
        end else if (busy) begin
            if (chk_stable && RST === 1'b1)
                chk("bus_stable", 32'({bus.direction_rw, bus.addr, bus.data}), 32'(cur_txn));
            delay--;
            if (delay == 0) begin
                bus.fb_done = 1'b1;
                bus.fb_rdata = rd_next;
                busy = 0;
                done_time = $time;
            end
        end
    end

    task automatic push_exp(input logic dir, input logic [7:0] a, input logic [7:0] d, input bit acare);
        exp_q.push_back({dir, a, d});
        exp_acare.push_back(acare);
    endtask

    task automatic run_req(input logic rw, input logic [7:0] a, input logic [7:0] wd,
                           input logic [7:0] exp_rdata, input logic exp_err, input bit chk_lat);
        int n;
        bit got;
        logic [16:0] mask;
        n = 0;
        @(negedge CLK_50MHZ);
        while (bus.req_ready !== 1'b1 && n < 50) begin
            @(negedge CLK_50MHZ);
            n++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
        obs_q.delete();
        bus.req_valid = 1'b1;
        bus.req_rw = rw;
        bus.req_addr = a;
        bus.req_wdata = wd;
        @(posedge CLK_50MHZ);
        #1 bus.req_valid = 1'b0;
        if (chk_lat) begin
            @(negedge CLK_50MHZ);
            chk("rd_issue_lat", 32'(bus.fb_action), 32'd1);
        end
        n = 0;
        got = 0;
        while (n < 1000 && !got) begin
            @(negedge CLK_50MHZ);
            if (bus.rsp_valid === 1'b1) got = 1;
            else n++;
        end
        chk("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rdata));
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_err));
            if (chk_lat) chk("rsp_lat", 32'($time - done_time), 32'd10);
            @(negedge CLK_50MHZ);
            chk("rsp_pulse", 32'(bus.rsp_valid), 32'd0);
            chk("ready_after", 32'(bus.req_ready), 32'd1);
        end
        chk("txn_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            mask = {1'b1, exp_acare[i] ? 8'hFF : 8'h00, exp_q[i][16] ? 8'hFF : 8'h00};
            chk("txn", 32'(obs_q[i] & mask), 32'(exp_q[i] & mask));
        end
        exp_q.delete();
        exp_acare.delete();
        rd_q.delete();
    endtask

    task automatic do_read(input logic [7:0] a, input logic [7:0] rdata);
        bit lat;
        lat = model_am;
        if (!model_am) push_exp(1'b1, a, 8'hFF, 1);
        model_am = 1;
        push_exp(1'b0, a, 8'h00, 1);
        rd_q.push_back(rdata);
        run_req(1'b0, a, 8'h00, rdata, 1'b0, lat);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] wd);
        logic [7:0] sr;
        logic err;
        model_am = 0;
        push_exp(1'b1, a, 8'h40, 1);
        push_exp(1'b1, a, wd, 1);
        push_exp(1'b1, a, 8'h70, 0);
        sr = 8'h00;
        for (int i = 0; i < POLL_MAX && i < sr_script.size(); i++) begin
            sr = sr_script[i];
            rd_q.push_back(sr);
            push_exp(1'b0, a, 8'h00, 1);
            if (sr[7]) break;
        end
        err = !sr[7] || ((sr & 8'h1A) != 8'h00);
        if (err) push_exp(1'b1, a, 8'h50, 0);
        run_req(1'b1, a, wd, sr, err, 0);
        sr_script.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_err"}, 32'(bus.rsp_err), 32'd0);
        chk({tag, "_rsp_rdata"}, 32'(bus.rsp_rdata), 32'd0);
        chk({tag, "_addr"}, 32'(bus.addr), 32'd0);
        chk({tag, "_data"}, 32'(bus.data), 32'd0);
        chk({tag, "_dir"}, 32'(bus.direction_rw), 32'd0);
        chk({tag, "_fb_action"}, 32'(bus.fb_action), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int rsp_cnt;
        int act_cnt;
        int kind;
        int nr;
        logic [7:0] a;
        RST = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_rw = 1'b0;
        bus.req_addr = 8'h00;
        bus.req_wdata = 8'h00;
        bus.fb_done = 1'b0;
        bus.fb_rdata = 8'h00;

        repeat (3) begin
            @(negedge CLK_50MHZ);
            chk_reset_outputs("reset");
        end
        RST = 1'b1;
        @(negedge CLK_50MHZ);
        chk("ready_after_reset", 32'(bus.req_ready), 32'd1);

        do_read(8'h35, 8'hC9);
        do_read(8'h36, 8'h5E);

        sr_script = '{8'h00, 8'h00, 8'h80};
        do_write(8'h35, 8'hC9);
        do_read(8'h35, 8'h17);

        sr_script = '{8'h90};
        do_write(8'h21, 8'h3C);

        sr_script = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        do_write(8'h42, 8'h99);

        // Reset while the program-data transaction is outstanding.
        slow_en = 1;
        slow_data = 8'h5A;
        chk_stable = 0;
        @(negedge CLK_50MHZ);
        obs_q.delete();
        bus.req_valid = 1'b1;
        bus.req_rw = 1'b1;
        bus.req_addr = 8'h12;
        bus.req_wdata = 8'h5A;
        @(posedge CLK_50MHZ);
        #1 bus.req_valid = 1'b0;
        n = 0;
        while (obs_q.size() < 2 && n < 50) begin
            @(negedge CLK_50MHZ);
            n++;
        end
        chk("abort_prdata_issued", 32'(obs_q.size()), 32'd2);
        @(negedge CLK_50MHZ);
        RST = 1'b0;
        @(negedge CLK_50MHZ);
        chk_reset_outputs("abort_reset");
        RST = 1'b1;
        rsp_cnt = 0;
        act_cnt = 0;
        repeat (20) begin
            @(negedge CLK_50MHZ);
            if (bus.rsp_valid === 1'b1) rsp_cnt++;
            if (bus.fb_action === 1'b1) act_cnt++;
        end
        chk("abort_no_rsp", 32'(rsp_cnt), 32'd0);
        chk("abort_no_action", 32'(act_cnt), 32'd0);
        chk("abort_txn_count", 32'(obs_q.size()), 32'd2);
        chk("abort_late_done_delivered", 32'(busy), 32'd0);
        slow_en = 0;
        chk_stable = 1;
        model_am = 0;
        do_read(8'h44, 8'hA7);

        for (int it = 0; it < 30; it++) begin
            a = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 1) == 1) begin
                kind = int'($urandom_range(0, 3));
                if (kind == 0) begin
                    for (int k = 0; k < POLL_MAX; k++) sr_script.push_back(8'($urandom) & 8'h7F);
                end else begin
                    nr = int'($urandom_range(0, POLL_MAX - 1));
                    for (int k = 0; k < nr; k++) sr_script.push_back(8'($urandom) & 8'h7F);
                    if (kind == 1) sr_script.push_back(8'h80 | (8'($urandom) & 8'h1A));
                    else sr_script.push_back(8'h80 | (8'($urandom) & 8'h65));
                end
                do_write(a, 8'($urandom));
            end else begin
                do_read(a, 8'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
